eth_tx_stream_arbiter: RTL
==========================

Name: eth_tx_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 64-bit Ethernet TX AXI-Stream (MAC tx_axis) between NUM_SOURCES requesters, e.g. the DMA TX engine and a control/pause-frame generator.
- Sits between the requesters and the MAC TX stream, in the gt_clock domain.
- Once a source is granted, it owns the stream until tlast. Frames longer than MAX_BEATS are truncated and flagged so a runaway source cannot stall the link.

Parameters:
- NUM_SOURCES, 2, number of upstream AXI-Stream requesters (2..8).
- DATA_BITS, 64, tdata width; tkeep width is DATA_BITS/8.
- MAX_BEATS, 190, maximum beats per frame (1518 B / 8 B, rounded up). A beat count reaching MAX_BEATS without tlast triggers truncation.

Ports:
- clock  in  1  GT user clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_SOURCES*DATA_BITS  source data; source i occupies slice [i*DATA_BITS +: DATA_BITS].
- s_axis_tkeep  in  NUM_SOURCES*DATA_BITS/8  source byte enables.
- s_axis_tlast  in  NUM_SOURCES  end of frame per source.
- s_axis_tuser  in  NUM_SOURCES  error/abort flag per source.
- s_axis_tvalid  in  NUM_SOURCES  per-source valid.
- s_axis_tready  out  NUM_SOURCES  per-source ready.
- m_axis_tdata  out  DATA_BITS  to MAC tx_axis_tdata.
- m_axis_tkeep  out  DATA_BITS/8  to MAC tx_axis_tkeep.
- m_axis_tlast  out  1  to MAC tx_axis_tlast.
- m_axis_tuser  out  1  to MAC tx_axis_tuser.
- m_axis_tvalid  out  1  to MAC tx_axis_tvalid.
- m_axis_tready  in  1  from MAC tx_axis_tready.
- grant  out  NUM_SOURCES  one-hot current owner; zero when idle.
- busy  out  1  high in PASS or DRAIN.
- oversize_err  out  1  one-cycle pulse when a frame is truncated.
- pkt_count  out  NUM_SOURCES*32  per-source completed-frame counters (optional feature).

Behaviour:
- States:
  - IDLE: no owner.
  - PASS: owner's beats forwarded to the MAC.
  - DRAIN: owner's excess beats discarded after truncation.
- Reset values:
  - state=IDLE, grant=0, busy=0, oversize_err=0.
  - rr_ptr=NUM_SOURCES-1, so source 0 has first priority.
  - beat counter=0, pkt_count=0.
  - m_axis_tvalid=0 and s_axis_tready=0 while in reset.
- IDLE:
  - If any s_axis_tvalid is set, pick the first valid source searching from rr_ptr+1 upward with wrap-around.
  - Register that choice in grant and go to PASS.
  - This costs exactly one bubble cycle; no data is forwarded in IDLE.
  - m_axis_tvalid=0 and all s_axis_tready=0.
- PASS:
  - m_axis_tdata/tkeep/tuser/tlast/tvalid come combinationally from the granted source slice.
  - s_axis_tready[g]=m_axis_tready; every other tready=0.
  - Zero-cycle latency; the beat counter increments on each handshake.
  - Handshake with tlast=1: go to IDLE, set rr_ptr=g, clear the counter, clear grant.
- Truncation:
  - Applies to a PASS handshake where counter==MAX_BEATS-1 and tlast=0.
  - That beat is emitted with m_axis_tlast=1 and m_axis_tuser=1 (forced).
  - oversize_err pulses for the next cycle. Next state is DRAIN.
- DRAIN:
  - m_axis_tvalid=0; s_axis_tready[g]=1; source beats are dropped.
  - Source beat with tlast=1 accepted: go to IDLE and set rr_ptr=g.
- A source deasserting tvalid mid-frame: grant is held; m_axis_tvalid follows the source (gap passes through to the MAC).
- Requests arriving during a final beat are not considered until IDLE on the next cycle. The back-to-back frame gap is therefore 1 cycle.
- A source with tvalid=0 is skipped; there is no reservation.
- Reset mid-frame: go to IDLE immediately. There is no forced tlast; the MAC is reset in the same domain.
- grant remains stable for the whole frame; it never changes while busy=1.

Optional Feature:
- ETH_TX_ARB_STATS_EN defined:
  - pkt_count[i] increments by 1 on each frame completion for source i: a PASS tlast handshake, or entry to DRAIN.
  - 32-bit counters, wrap from 0xFFFFFFFF to 0, cleared by reset.
- Not defined: pkt_count is tied to 0 and no counter logic is synthesised. The port list is unchanged.

Test Plan:
- Src0 sends a 4-beat frame (tkeep last=0x0F), m_axis_tready=1 -> 1 idle cycle, then 4 beats identical on m_axis; grant=01 for 4 cycles; tlast on beat 4; busy then drops.
- Src0 and src1 both valid continuously, 2-beat frames -> grant alternates 01,10,01,10; 1-cycle gap between frames; no beat from the non-granted source leaks.
- Src1 sends a 200-beat frame without tlast until beat 200, MAX_BEATS=190 -> beat 190 out with tlast=1 and tuser=1; oversize_err one pulse; beats 191-200 absorbed (s_tready=1, m_tvalid=0); then IDLE.
- m_axis_tready toggled 1,0,0,1 mid-frame -> s_axis_tready[g] mirrors it; the source holds data; no beat is duplicated or lost; beat counter counts handshakes only.
- reset asserted on beat 3 of a 6-beat frame -> next cycle grant=0, m_axis_tvalid=0; after release, source 0 wins a tie against source 1.
- With ETH_TX_ARB_STATS_EN: 3 frames on src0 and 1 truncated frame on src1 -> pkt_count[0]=3, pkt_count[1]=1. Without the macro, both read 0.

Source files
------------

// File: rtl/eth_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one MAC TX AXI-Stream among NUM_SOURCES requesters.
// Define ETH_TX_ARB_STATS_EN to build the per-source completed-frame counters on pkt_count.
`timescale 1ns/1ps
module eth_tx_stream_arbiter #(
  parameter int unsigned NUM_SOURCES = 2,
  parameter int unsigned DATA_BITS   = 64,
  parameter int unsigned MAX_BEATS   = 190
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_SOURCES*DATA_BITS-1:0]  s_axis_tdata,
  input  logic [NUM_SOURCES*DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic [NUM_SOURCES-1:0]            s_axis_tlast,
  input  logic [NUM_SOURCES-1:0]            s_axis_tuser,
  input  logic [NUM_SOURCES-1:0]            s_axis_tvalid,
  output logic [NUM_SOURCES-1:0]            s_axis_tready,
  output logic [DATA_BITS-1:0]              m_axis_tdata,
  output logic [DATA_BITS/8-1:0]            m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [NUM_SOURCES-1:0]            grant,
  output logic                              busy,
  output logic                              oversize_err,
  output logic [NUM_SOURCES*32-1:0]         pkt_count
);

  localparam int unsigned KEEP_BITS = DATA_BITS / 8;
  localparam int unsigned IDX_W     = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t                 state, state_next;
  logic [NUM_SOURCES-1:0] grant_next;
  logic [IDX_W-1:0]       owner, owner_next;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0]       beat_cnt, beat_cnt_next;
  logic                   oversize_next;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand;

  logic [DATA_BITS-1:0]   sel_data;
  logic [KEEP_BITS-1:0]   sel_keep;
  logic                   sel_last, sel_user, sel_valid;
  logic                   hs, trunc;

  // Round-robin search starting one past the last owner, with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_SOURCES; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_SOURCES);
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_data  = s_axis_tdata[owner*DATA_BITS +: DATA_BITS];
    sel_keep  = s_axis_tkeep[owner*KEEP_BITS +: KEEP_BITS];
    sel_last  = s_axis_tlast[owner];
    sel_user  = s_axis_tuser[owner];
    sel_valid = s_axis_tvalid[owner];
  end

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    owner_next    = owner;
    rr_ptr_next   = rr_ptr;
    beat_cnt_next = beat_cnt;
    oversize_next = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    hs            = 1'b0;
    trunc         = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next           = PASS;
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          owner_next           = pick_idx;
          beat_cnt_next        = '0;
        end
      end
      PASS: begin
        // The last permitted beat is closed off as an errored frame.
        trunc                = (beat_cnt == CNT_W'(MAX_BEATS - 1)) && !sel_last;
        m_axis_tdata         = sel_data;
        m_axis_tkeep         = sel_keep;
        m_axis_tlast         = sel_last | trunc;
        m_axis_tuser         = sel_user | trunc;
        m_axis_tvalid        = sel_valid;
        s_axis_tready[owner] = m_axis_tready;
        hs                   = sel_valid && m_axis_tready;
        if (hs) begin
          if (sel_last) begin
            state_next    = IDLE;
            rr_ptr_next   = owner;
            grant_next    = '0;
            beat_cnt_next = '0;
          end else if (trunc) begin
            state_next    = DRAIN;
            beat_cnt_next = '0;
            oversize_next = 1'b1;
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        s_axis_tready[owner] = 1'b1;
        if (sel_valid && sel_last) begin
          state_next  = IDLE;
          rr_ptr_next = owner;
          grant_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (reset) begin
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      owner        <= '0;
      rr_ptr       <= IDX_W'(NUM_SOURCES - 1);
      beat_cnt     <= '0;
      oversize_err <= 1'b0;
    end else begin
      state        <= state_next;
      grant        <= grant_next;
      owner        <= owner_next;
      rr_ptr       <= rr_ptr_next;
      beat_cnt     <= beat_cnt_next;
      oversize_err <= oversize_next;
    end
  end

  assign busy = (state != IDLE);

`ifdef ETH_TX_ARB_STATS_EN
  logic [31:0] frame_cnt [NUM_SOURCES];

  // A truncated frame counts as completed when it is cut, not when its drain ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) frame_cnt[i] <= '0;
    end else if ((state == PASS) && hs && (sel_last || trunc)) begin
      frame_cnt[owner] <= frame_cnt[owner] + 32'd1;
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) pkt_count[i*32 +: 32] = frame_cnt[i];
  end
`else
  assign pkt_count = '0;
`endif

endmodule
